// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: one 128-bit state in, LANES inverse S-box
// evaluations per clock, one 128-bit result out, valid/ready on both sides.
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NGROUPS = 16 / LANES;
    localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [127:0]   work_reg, work_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [7:0]     lane_in  [LANES];
    logic [7:0]     lane_out [LANES];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] bb;
        p  = 8'h00;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) p = p ^ bb;
            bb = {bb[6:0], 1'b0} ^ (bb[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); the chain also maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    // Byte k of the group lives at byte index cnt*LANES+k; byte 0 is the MSB.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi]  = work_reg[8*(15 - (int'(cnt_reg)*LANES + gi)) +: 8];
            assign lane_out[gi] = inv_sbox(lane_in[gi]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_state;
                    cnt_next   = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < LANES; i++) begin
                    work_next[8*(15 - (int'(cnt_reg)*LANES + i)) +: 8] = lane_out[i];
                end
                // Counter parks on the last group; it is only cleared on entry to BUSY.
                if (cnt_reg == CW'(NGROUPS - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == BUSY) || (state_reg == DONE);
    assign out_state = work_reg;

endmodule
